dec_unbinder_seq: RTL and testbench
===================================

Name: dec_unbinder_seq

Overview:
Decode-side counterpart of the encoder binder pack. The encoder binder rotates each level hypervector left (toward MSB) by its per-feature constant SHIFTS[i]. This block captures one bound set of FEATURES_PER_CC hypervectors, undoes each binding with a right rotation by the same SHIFTS[i], and streams the recovered level hypervectors out one per handshake. It uses a single time-multiplexed rotator instead of one binder per feature, and sits between the bound-HV store and the level-HV lookup/similarity logic.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- FEATURES_PER_CC, 8, number of features per compute cluster (number of input HVs).
- SHIFT_W, $clog2(HV_DIM), width of one shift amount.
- IDX_W, $clog2(FEATURES_PER_CC) (min 1), width of the feature index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- start_decoding  input  1  one-cycle start pulse.
- en  input  1  cluster enable; start is honoured only when en=1.
- shifted_hv  input  [HV_DIM-1:0] x FEATURES_PER_CC  bound HVs; sampled only on an accepted start.
- level_hv  output  [HV_DIM-1:0]  recovered level HV for feature level_idx.
- level_idx  output  IDX_W  feature index of level_hv.
- level_valid  output  1  level_hv/level_idx valid.
- level_ready  input  1  downstream accepts when level_valid && level_ready.
- busy  output  1  high from accepted start until the last beat is accepted.
- done  output  1  one-cycle pulse in the cycle after the last beat is accepted.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - Outputs: level_hv=0, level_idx=0, level_valid=0, busy=0, done=0.
  - State: FSM to IDLE, capture buffer cleared.
  - Reset mid-operation aborts immediately; no further beats, no done pulse.
- FSM states: IDLE, ROT, OUT, FIN.
  - IDLE: start_decoding && en → capture all shifted_hv into the internal buffer; idx=0; busy=1; go to ROT. A start with en=0 is ignored.
  - ROT: level_hv <= rotr(buf[idx], SHIFTS[idx]); level_idx <= idx; level_valid <= 1; go to OUT.
  - OUT: hold level_hv, level_idx and level_valid stable until level_ready.
    - On handshake with idx < FEATURES_PER_CC-1: level_valid <= 0; idx++; go to ROT.
    - On handshake with idx == FEATURES_PER_CC-1: level_valid <= 0; go to FIN.
  - FIN: done=1 for exactly one cycle; busy <= 0; go to IDLE.
- Rotation rule: rotr(x,s)[j] = x[(j+s) mod HV_DIM]. s is taken mod HV_DIM; s=0 is pass-through. Purely combinational in the sub-module; it is registered only in the ROT state.
- Latency and throughput:
  - First level_valid rises 2 cycles after the accepted start edge.
  - Each beat costs 2 cycles (ROT + OUT) with ready held high.
  - Total: 2*FEATURES_PER_CC cycles from start to last handshake, plus 1 cycle to done.
- Boundary conditions:
  - start_decoding while busy: ignored; the buffer is not overwritten.
  - shifted_hv changing after capture: no effect on the current run.
  - level_ready high while level_valid=0: no effect.
  - FEATURES_PER_CC=1: single beat, then FIN.
  - start_decoding in the FIN cycle: ignored; a new start is accepted the following cycle.
- Exact-inverse requirement: rotr(rotl(x,s),s) == x for all x and all s.

Decomposition:
- Shared package (the package already holding HV_DIM, FEATURES_PER_CC and SHIFTS):
  - Add the typedef hv_t = logic [HV_DIM-1:0].
  - Add the state enum dec_state_t {IDLE, ROT, OUT, FIN}.
  - Keep SHIFTS as the single source of truth, read by both the encoder and this block.
- Sub-module: hv_rotr (combinational parameterised barrel right-rotator, log2 stages; ports x, s, y).

Test Plan:
- HV_DIM=8, FEATURES_PER_CC=3, SHIFTS={1,2,7}; shifted_hv={8'h02, 8'h04, 8'h80}; start with en=1, ready=1 → beats (idx0, 8'h01), (idx1, 8'h01), (idx2, 8'h01). First valid 2 cycles after start; done at cycle 7; busy low after done.
- Same stimulus with level_ready held 0 for 5 cycles on beat 1 → level_hv=8'h01 and idx=1 held stable throughout; no beat is skipped or duplicated.
- start_decoding with en=0 → busy stays 0 and no valid. Second start mid-run with different shifted_hv → output sequence unchanged.
- rst=1 asserted during beat 1 → next cycle all outputs 0 and FSM in IDLE; no done pulse. A subsequent start decodes normally.
- Random round-trip: 1000 random x, encoder rotl by SHIFTS[i] feeding this block → every level_hv == original x, including SHIFTS=0 and HV_DIM-1.

Source files
------------

// File: rtl/dec_unbinder_seq_pkg.sv
// Shared decoder/encoder constants: hypervector geometry, per-feature
// binding shifts and the unbinder state encoding.
package dec_unbinder_seq_pkg;

    // Width of an index able to address n items, never narrower than 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned HV_DIM          = 1024;
    localparam int unsigned FEATURES_PER_CC = 8;
    localparam int unsigned SHIFT_W         = clog2_min1(HV_DIM);
    localparam int unsigned IDX_W           = clog2_min1(FEATURES_PER_CC);

    typedef logic [HV_DIM-1:0] hv_t;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        OUT,
        FIN
    } dec_state_t;

    // Per-feature binding rotation; element [i] belongs to feature i.
    // Read by both the encoder binder and the decoder unbinder.
    localparam logic [FEATURES_PER_CC-1:0][31:0] SHIFTS = {
        32'd1023, 32'd613, 32'd401, 32'd257,
        32'd97,   32'd31,  32'd7,   32'd1
    };

endpackage

// File: rtl/dec_unbinder_seq_hv_rotr.sv
// Combinational barrel right-rotator: y[j] = x[(j + s) mod W].
// Stage k rotates by 2^k mod W, so the stages compose to s mod W
// even when W is not a power of two.
module hv_rotr #(
    parameter int unsigned W  = 1024,
    parameter int unsigned SW = 10
) (
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] s,
    output logic [W-1:0]  y
);

    logic [W-1:0] stage [SW+1];

    assign stage[0] = x;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int unsigned AMT = (32'd1 << k) % W;
        logic [W-1:0] rot;
        // Fixed right rotation by this stage's weight
        assign rot = (stage[k] >> AMT) | (stage[k] << (W - AMT));
        assign stage[k+1] = s[k] ? rot : stage[k];
    end

    assign y = stage[SW];

endmodule

// File: rtl/dec_unbinder_seq.sv
// Decoder unbinder: captures one bound set of hypervectors, undoes each
// feature's binding rotation with a single shared rotator and streams the
// recovered level hypervectors out with a valid/ready handshake.
module dec_unbinder_seq #(
    parameter int unsigned HV_DIM          = dec_unbinder_seq_pkg::HV_DIM,
    parameter int unsigned FEATURES_PER_CC = dec_unbinder_seq_pkg::FEATURES_PER_CC,
    parameter logic [FEATURES_PER_CC-1:0][31:0] SHIFTS = dec_unbinder_seq_pkg::SHIFTS,
    parameter int unsigned SHIFT_W = dec_unbinder_seq_pkg::clog2_min1(HV_DIM),
    parameter int unsigned IDX_W   = dec_unbinder_seq_pkg::clog2_min1(FEATURES_PER_CC)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_decoding,
    input  logic                                   en,
    input  logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] shifted_hv,
    output logic [HV_DIM-1:0]                      level_hv,
    output logic [IDX_W-1:0]                       level_idx,
    output logic                                   level_valid,
    input  logic                                   level_ready,
    output logic                                   busy,
    output logic                                   done
);

    import dec_unbinder_seq_pkg::*;

    dec_state_t                             state;
    logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] cap_q;
    logic [IDX_W-1:0]                       idx_q;
    logic [SHIFT_W-1:0]                     shift_amt;
    logic [HV_DIM-1:0]                      rot_y;

    // Shift amount for the feature currently being unbound
    always_comb begin
        shift_amt = '0;
        shift_amt = SHIFT_W'(SHIFTS[idx_q] % HV_DIM);
    end

    hv_rotr #(
        .W  (HV_DIM),
        .SW (SHIFT_W)
    ) u_rotr (
        .x (cap_q[idx_q]),
        .s (shift_amt),
        .y (rot_y)
    );

    // Capture / rotate / handshake sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cap_q       <= '0;
            idx_q       <= '0;
            level_hv    <= '0;
            level_idx   <= '0;
            level_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_decoding && en) begin
                        cap_q <= shifted_hv;
                        idx_q <= '0;
                        busy  <= 1'b1;
                        state <= ROT;
                    end
                end
                ROT: begin
                    level_hv    <= rot_y;
                    level_idx   <= idx_q;
                    level_valid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (level_ready) begin
                        level_valid <= 1'b0;
                        // done is raised here so it is visible during FIN
                        if (idx_q == IDX_W'(FEATURES_PER_CC - 1)) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            state <= ROT;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Bench for dec_unbinder_seq: directed timing/handshake scenarios on an
// 8-bit, 3-feature instance plus randomized bind/unbind round trips on it
// and on a 16-bit single-feature instance with a zero shift.
module tb_dec_unbinder_seq;

    localparam int unsigned AW = 8;
    localparam int unsigned AF = 3;
    localparam int unsigned BW = 16;

    int unsigned a_shift [AF] = '{1, 2, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                 a_start = 1'b0;
    logic                 a_en    = 1'b1;
    logic [AF-1:0][AW-1:0] a_shv  = '0;
    logic [AW-1:0]        a_hv;
    logic [1:0]           a_idx;
    logic                 a_valid;
    logic                 a_ready = 1'b1;
    logic                 a_busy;
    logic                 a_done;

    logic                 b_start = 1'b0;
    logic [0:0][BW-1:0]   b_shv   = '0;
    logic [BW-1:0]        b_hv;
    logic [0:0]           b_idx;
    logic                 b_valid;
    logic                 b_busy;
    logic                 b_done;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    dec_unbinder_seq #(
        .HV_DIM          (AW),
        .FEATURES_PER_CC (AF),
        .SHIFTS          ({32'd7, 32'd2, 32'd1})
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .start_decoding (a_start),
        .en             (a_en),
        .shifted_hv     (a_shv),
        .level_hv       (a_hv),
        .level_idx      (a_idx),
        .level_valid    (a_valid),
        .level_ready    (a_ready),
        .busy           (a_busy),
        .done           (a_done)
    );

    dec_unbinder_seq #(
        .HV_DIM          (BW),
        .FEATURES_PER_CC (1),
        .SHIFTS          ({32'd0})
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .start_decoding (b_start),
        .en             (1'b1),
        .shifted_hv     (b_shv),
        .level_hv       (b_hv),
        .level_idx      (b_idx),
        .level_valid    (b_valid),
        .level_ready    (1'b1),
        .busy           (b_busy),
        .done           (b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rotations on plain integers
    function automatic logic [31:0] rotl_m(input logic [31:0] x, input int unsigned s, input int unsigned w);
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        int unsigned r = s % w;
        if (r == 0) return x & mask;
        return ((x << r) | ((x & mask) >> (w - r))) & mask;
    endfunction

    function automatic logic [31:0] rotr_m(input logic [31:0] x, input int unsigned s, input int unsigned w);
        return rotl_m(x, w - (s % w), w);
    endfunction

    // Observations from the most recent collect_a call
    logic [AW-1:0] beat_hv [$];
    int unsigned   beat_idx [$];
    int unsigned   n_first_valid, n_done, done_cnt, last_busy_n;
    bit            busy_seen;

    // Step instance A for a bounded number of cycles, sampling on the
    // falling edge and driving ready/start for the next rising edge.
    task automatic collect_a(input int unsigned stall_beat, input int unsigned stall_len,
                             input int unsigned poke_n, input int unsigned cycles);
        int unsigned   stalled = 0;
        logic [AW-1:0] held_hv = '0;
        logic [1:0]    held_idx = '0;
        beat_hv.delete();
        beat_idx.delete();
        n_first_valid = 0; n_done = 0; done_cnt = 0; last_busy_n = 0; busy_seen = 0;
        for (int unsigned n = 1; n <= cycles; n++) begin
            @(negedge clk);
            if (a_busy) begin busy_seen = 1; last_busy_n = n; end
            if (a_done) begin done_cnt++; n_done = n; end
            if (!a_ready) begin
                check("stall_valid", a_valid, 1'b1);
                check("stall_hv", a_hv, held_hv);
                check("stall_idx", a_idx, held_idx);
            end
            if (a_valid) begin
                if (n_first_valid == 0) n_first_valid = n;
                if (beat_idx.size() == stall_beat && stalled < stall_len) begin
                    a_ready  = 1'b0;
                    held_hv  = a_hv;
                    held_idx = a_idx;
                    stalled++;
                end else begin
                    a_ready = 1'b1;
                    beat_hv.push_back(a_hv);
                    beat_idx.push_back(a_idx);
                end
            end else begin
                a_ready = 1'b1;
            end
            a_start = (n == poke_n);
            if (n == poke_n) begin
                for (int i = 0; i < AF; i++) a_shv[i] = AW'($urandom);
            end
        end
        a_start = 1'b0;
        a_ready = 1'b1;
    endtask

    task automatic pulse_a(input bit en_val);
        @(negedge clk);
        a_en    = en_val;
        a_start = 1'b1;
    endtask

    task automatic check_directed_beats(input string tag);
        check({tag, "_count"}, beat_idx.size(), AF);
        for (int i = 0; i < AF; i++) begin
            check({tag, "_idx"}, (i < beat_idx.size()) ? beat_idx[i] : 32'hffff_ffff, i);
            check({tag, "_hv"}, (i < beat_hv.size()) ? beat_hv[i] : 'x, 8'h01);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] xa [AF];
        logic [BW-1:0] xb;
        int unsigned   sb, sl, nd;
        logic [BW-1:0] bq [$];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hv", a_hv, 0);
        check("rst_idx", a_idx, 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_b_valid", b_valid, 0);
        rst = 1'b0;

        // Directed decode with ready held high: timing and values
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(99, 0, 0, 20);
        check_directed_beats("dir");
        check("dir_first_valid", n_first_valid, 2);
        check("dir_done_n", n_done, 7);
        check("dir_done_cnt", done_cnt, 1);
        check("dir_busy_last", last_busy_n, 7);

        // Beat 1 stalled for 5 cycles
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(1, 5, 0, 25);
        check_directed_beats("stall");
        check("stall_done_n", n_done, 12);

        // Start while disabled is ignored
        pulse_a(1'b0);
        collect_a(99, 0, 0, 15);
        a_en = 1'b1;
        check("en0_beats", beat_idx.size(), 0);
        check("en0_busy", busy_seen, 0);

        // Restart mid-run with new data does not disturb the run
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(99, 0, 3, 20);
        check_directed_beats("midstart");
        check("midstart_done_cnt", done_cnt, 1);

        // Start during the done cycle is ignored
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(99, 0, 7, 20);
        check("finstart_busy_last", last_busy_n, 7);
        check("finstart_done_cnt", done_cnt, 1);

        // Reset during beat 1 aborts the run
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(99, 0, 0, 4);
        check("pre_rst_valid", a_valid, 1);
        check("pre_rst_idx", a_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hv", a_hv, 0);
        check("abort_idx", a_idx, 0);
        check("abort_valid", a_valid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        collect_a(99, 0, 0, 12);
        check("abort_beats", beat_idx.size(), 0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_busy_seen", busy_seen, 0);

        // Decodes normally after the abort
        a_shv[0] = 8'h02; a_shv[1] = 8'h04; a_shv[2] = 8'h80;
        pulse_a(1'b1);
        collect_a(99, 0, 0, 20);
        check_directed_beats("post_rst");
        check("post_rst_done_n", n_done, 7);

        // Random round trips on A with random stalls
        for (int r = 0; r < 334; r++) begin
            for (int i = 0; i < AF; i++) begin
                xa[i]    = AW'($urandom);
                a_shv[i] = AW'(rotl_m(32'(xa[i]), a_shift[i], AW));
            end
            sb = $urandom_range(0, AF);
            sl = $urandom_range(0, 3);
            pulse_a(1'b1);
            collect_a(sb, sl, 0, 2 * AF + 1 + sl + 3);
            check("rt_count", beat_idx.size(), AF);
            for (int i = 0; i < AF; i++) begin
                check("rt_idx", (i < beat_idx.size()) ? beat_idx[i] : 32'hffff_ffff, i);
                check("rt_hv", (i < beat_hv.size()) ? beat_hv[i] : 'x, xa[i]);
                check("rt_model", AW'(rotr_m(32'(a_shv[i]), a_shift[i], AW)), xa[i]);
            end
            check("rt_done_n", n_done, 2 * AF + 1 + ((sb < AF) ? sl : 0));
        end

        // Random round trips on the single-feature, zero-shift instance
        for (int r = 0; r < 300; r++) begin
            xb = BW'($urandom);
            b_shv[0] = BW'(rotl_m(32'(xb), 0, BW));
            @(negedge clk);
            b_start = 1'b1;
            bq.delete();
            nd = 0;
            for (int unsigned n = 1; n <= 6; n++) begin
                @(negedge clk);
                b_start = 1'b0;
                if (b_valid) bq.push_back(b_hv);
                if (b_done) nd = n;
            end
            check("b_count", bq.size(), 1);
            check("b_hv", (bq.size() > 0) ? bq[0] : 'x, xb);
            check("b_idx", b_idx, 0);
            check("b_done_n", nd, 3);
            check("b_busy_end", b_busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
